// File: rtl/rv32_ctrl_pkg.sv
// rv32_ctrl_pkg: shared opcode, state, ALU, immediate and RF write-source encodings
// for the multi-cycle RV32I control unit.
`default_nettype none

package rv32_ctrl_pkg;

  localparam logic [6:0] OP_TYPE_R  = 7'b0110011;
  localparam logic [6:0] OP_TYPE_I  = 7'b0010011;
  localparam logic [6:0] OP_TYPE_L  = 7'b0000011;
  localparam logic [6:0] OP_TYPE_S  = 7'b0100011;
  localparam logic [6:0] OP_TYPE_B  = 7'b1100011;
  localparam logic [6:0] OP_TYPE_LU = 7'b0110111;
  localparam logic [6:0] OP_TYPE_AU = 7'b0010111;
  localparam logic [6:0] OP_TYPE_J  = 7'b1101111;
  localparam logic [6:0] OP_TYPE_JL = 7'b1100111;

  typedef enum logic [3:0] {
    FETCH, DECODE, R_EXE, I_EXE, U_EXE, UA_EXE, J_EXE, JI_EXE,
    B_EXE, L_EXE, L_MEM, L_WB, S_EXE, S_MEM, NOP_EXE, TRAP
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  localparam logic [2:0] IMM_I     = 3'd0;
  localparam logic [2:0] IMM_I_ALU = 3'd1;
  localparam logic [2:0] IMM_S     = 3'd2;
  localparam logic [2:0] IMM_B     = 3'd3;
  localparam logic [2:0] IMM_U     = 3'd4;
  localparam logic [2:0] IMM_J     = 3'd5;

  localparam logic [1:0] RF_SRC_ALU  = 2'd0;
  localparam logic [1:0] RF_SRC_LOAD = 2'd1;
  localparam logic [1:0] RF_SRC_IMM  = 2'd2;
  localparam logic [1:0] RF_SRC_PC   = 2'd3;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/cu_alu_decoder.sv
// cu_alu_decoder: combinational {opcode, funct3, funct7[5]} -> 4-bit ALU control.
`default_nettype none

module cu_alu_decoder
  import rv32_ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (op)
      OP_TYPE_R: alu_control = {funct7_b5, funct3};
      // Only the shifts carry an funct7 qualifier among I-type ALU ops
      OP_TYPE_I: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) alu_control = {funct7_b5, funct3};
        else                                      alu_control = {1'b0, funct3};
      end
      OP_TYPE_B, OP_TYPE_JL: alu_control = {1'b0, funct3};
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle RV32I control FSM with bus stall and timeout.
// Optional ILLEGAL_TRAP_EN: unknown opcodes lock the FSM in TRAP until reset.
`default_nettype none

module multicycle_control_unit
  import rv32_ctrl_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        instr_valid,
  input  logic        bus_ready,
  output logic        PCEn,
  output logic        regFile_wr_en,
  output logic        AluSrcMuxSel,
  output logic [1:0]  RFWriteDataSrcMuxSel,
  output logic        bus_req,
  output logic        dataMem_wr_en,
  output logic [2:0]  immExtType,
  output logic [1:0]  storeType,
  output logic [2:0]  loadType,
  output logic        Bbranch,
  output logic        Jbranch,
  output logic        JIbranch,
  output logic [3:0]  ALUControl,
  output logic        bus_err,
  output logic        illegal_instr
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

  state_e          state;
  logic [31:0]     instr;
  logic [CNT_W-1:0] cnt;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [3:0] alu_dec;
  logic       timeout;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};
  assign timeout = (state == L_MEM || state == S_MEM) && !bus_ready && (cnt == CNT_LAST);

  cu_alu_decoder u_alu_dec (
    .op          (opcode),
    .funct3      (funct3),
    .funct7_b5   (instr[30]),
    .alu_control (alu_dec)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      instr <= INSTR_NOP;
      cnt   <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (instr_valid) begin
            instr <= instrCode;
            state <= DECODE;
          end
        end
        DECODE: begin
          case (opcode)
            OP_TYPE_R:  state <= R_EXE;
            OP_TYPE_I:  state <= I_EXE;
            OP_TYPE_LU: state <= U_EXE;
            OP_TYPE_AU: state <= UA_EXE;
            OP_TYPE_J:  state <= J_EXE;
            OP_TYPE_JL: state <= JI_EXE;
            OP_TYPE_B:  state <= B_EXE;
            OP_TYPE_L:  state <= L_EXE;
            OP_TYPE_S:  state <= S_EXE;
`ifdef ILLEGAL_TRAP_EN
            default:    state <= TRAP;
`else
            default:    state <= NOP_EXE;
`endif
          endcase
        end
        L_EXE: state <= L_MEM;
        S_EXE: state <= S_MEM;
        // A late bus_ready on the final count still completes normally
        L_MEM, S_MEM: begin
          if (bus_ready) begin
            cnt <= '0;
            if (state == L_MEM) state <= L_WB;
            else                state <= FETCH;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= FETCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TRAP:    state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    PCEn                 = 1'b0;
    regFile_wr_en        = 1'b0;
    AluSrcMuxSel         = 1'b0;
    RFWriteDataSrcMuxSel = RF_SRC_ALU;
    bus_req              = 1'b0;
    dataMem_wr_en        = 1'b0;
    immExtType           = IMM_I;
    storeType            = 2'b00;
    loadType             = 3'b000;
    Bbranch              = 1'b0;
    Jbranch              = 1'b0;
    JIbranch             = 1'b0;
    ALUControl           = ALU_ADD;
    bus_err              = 1'b0;
    illegal_instr        = 1'b0;

    if (state != FETCH && state != TRAP) begin
      ALUControl = alu_dec;
      case (opcode)
        OP_TYPE_I:  begin AluSrcMuxSel = 1'b1; immExtType = IMM_I_ALU; end
        OP_TYPE_LU: begin RFWriteDataSrcMuxSel = RF_SRC_IMM; immExtType = IMM_U; end
        OP_TYPE_AU: begin RFWriteDataSrcMuxSel = RF_SRC_PC;  immExtType = IMM_U; end
        OP_TYPE_J:  begin RFWriteDataSrcMuxSel = RF_SRC_PC;  immExtType = IMM_J; end
        OP_TYPE_JL: begin RFWriteDataSrcMuxSel = RF_SRC_PC;  AluSrcMuxSel = 1'b1; end
        OP_TYPE_B:  immExtType = IMM_B;
        OP_TYPE_L:  begin
          AluSrcMuxSel         = 1'b1;
          RFWriteDataSrcMuxSel = RF_SRC_LOAD;
          loadType             = funct3;
        end
        OP_TYPE_S:  begin
          AluSrcMuxSel = 1'b1;
          immExtType   = IMM_S;
          storeType    = funct3[1:0];
        end
        default: ;
      endcase
    end

    case (state)
      R_EXE, I_EXE, U_EXE, UA_EXE: begin PCEn = 1'b1; regFile_wr_en = 1'b1; end
      J_EXE:   begin PCEn = 1'b1; regFile_wr_en = 1'b1; Jbranch  = 1'b1; end
      JI_EXE:  begin PCEn = 1'b1; regFile_wr_en = 1'b1; JIbranch = 1'b1; end
      B_EXE:   begin PCEn = 1'b1; Bbranch = 1'b1; end
      NOP_EXE: PCEn = 1'b1;
      L_MEM: begin
        bus_req = 1'b1;
        bus_err = timeout;
        PCEn    = timeout;
      end
      L_WB: begin PCEn = 1'b1; regFile_wr_en = 1'b1; end
      S_MEM: begin
        bus_req       = 1'b1;
        dataMem_wr_en = 1'b1;
        bus_err       = timeout;
        PCEn          = bus_ready | timeout;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: illegal_instr = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: randomized scoreboard bench for multicycle_control_unit.
`default_nettype none

module tb_multicycle_control_unit;

  localparam int BT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instrCode = '0;
  logic        instr_valid = 1'b0;
  logic        bus_ready = 1'b0;
  logic        PCEn, regFile_wr_en, AluSrcMuxSel, bus_req, dataMem_wr_en;
  logic [1:0]  RFWriteDataSrcMuxSel, storeType;
  logic [2:0]  immExtType, loadType;
  logic        Bbranch, Jbranch, JIbranch, bus_err, illegal_instr;
  logic [3:0]  ALUControl;
  logic [23:0] outs;

  always #5 clk = ~clk;

  multicycle_control_unit #(.BUS_TIMEOUT(BT), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .instrCode(instrCode), .instr_valid(instr_valid),
    .bus_ready(bus_ready), .PCEn(PCEn), .regFile_wr_en(regFile_wr_en),
    .AluSrcMuxSel(AluSrcMuxSel), .RFWriteDataSrcMuxSel(RFWriteDataSrcMuxSel),
    .bus_req(bus_req), .dataMem_wr_en(dataMem_wr_en), .immExtType(immExtType),
    .storeType(storeType), .loadType(loadType), .Bbranch(Bbranch), .Jbranch(Jbranch),
    .JIbranch(JIbranch), .ALUControl(ALUControl), .bus_err(bus_err),
    .illegal_instr(illegal_instr)
  );

  assign outs = {PCEn, regFile_wr_en, AluSrcMuxSel, RFWriteDataSrcMuxSel, bus_req,
                 dataMem_wr_en, immExtType, storeType, loadType, Bbranch, Jbranch,
                 JIbranch, ALUControl, bus_err, illegal_instr};

  typedef struct packed {
    int lat; int breq; int wr; int rfsel; int alu; int alusrc;
    int imm; int berr; int br; int ld; int st; int dmem;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   vectors = 0, miscompares = 0;
  int   cur_wait = 0, req_cnt = 0;
  bit   mon_en = 1'b0;
  int   cyc = 0, start = 0, n_breq = 0, n_wr = 0;

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit known_op(input logic [6:0] op);
    return op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63 ||
           op == 7'h37 || op == 7'h17 || op == 7'h6F || op == 7'h67;
  endfunction

  // Reference: what the core must show on its PCEn cycle, and per-instruction totals
  function automatic exp_t model(input logic [31:0] ins, input int w);
    exp_t e;
    int f3, f7b;
    f3  = int'(ins[14:12]);
    f7b = int'(ins[30]);
    e = '0;
    e.lat = 3;
    case (ins[6:0])
      7'h33: begin e.wr = 1; e.alu = f7b * 8 + f3; end
      7'h13: begin
        e.wr = 1; e.alusrc = 1; e.imm = 1;
        e.alu = (f3 == 1 || f3 == 5) ? f7b * 8 + f3 : f3;
      end
      7'h37: begin e.wr = 1; e.rfsel = 2; e.imm = 4; end
      7'h17: begin e.wr = 1; e.rfsel = 3; e.imm = 4; end
      7'h6F: begin e.wr = 1; e.rfsel = 3; e.imm = 5; e.br = 2; end
      7'h67: begin e.wr = 1; e.rfsel = 3; e.alusrc = 1; e.alu = f3; e.br = 1; end
      7'h63: begin e.imm = 3; e.alu = f3; e.br = 4; end
      7'h03: begin
        e.alusrc = 1; e.rfsel = 1; e.ld = f3;
        if (w < BT) begin e.lat = w + 5; e.breq = w + 1; e.wr = 1; end
        else begin e.lat = 3 + BT; e.breq = BT; e.berr = 1; end
      end
      7'h23: begin
        e.alusrc = 1; e.imm = 2; e.st = f3 % 4; e.dmem = 1;
        if (w < BT) begin e.lat = w + 4; e.breq = w + 1; end
        else begin e.lat = 3 + BT; e.breq = BT; e.berr = 1; end
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr(input int kind);
    logic [31:0] ins;
    logic [6:0]  op;
    ins = $urandom;
    case (kind)
      0: op = 7'h33; 1: op = 7'h13; 2: op = 7'h03; 3: op = 7'h23; 4: op = 7'h63;
      5: op = 7'h37; 6: op = 7'h17; 7: op = 7'h6F; 8: op = 7'h67;
      default: begin
        op = 7'h7F;
        while (known_op(op)) op = 7'($urandom);
      end
    endcase
    ins[6:0] = op;
    return ins;
  endfunction

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6)  return $urandom_range(0, 5);
    if (r == 6) return BT - 1;
    if (r == 7) return BT;
    return $urandom_range(BT + 1, 30);
  endfunction

  // Bus responder: raise bus_ready on the (cur_wait+1)-th requesting cycle
  initial forever begin
    @(posedge clk); #1;
    if (bus_req) begin
      bus_ready = (req_cnt == cur_wait);
      req_cnt++;
    end else begin
      bus_ready = 1'b0;
      req_cnt   = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    if (mon_en) begin
      if (instr_valid) begin start = cyc; n_breq = 0; n_wr = 0; end
      if (bus_req) n_breq++;
      if (regFile_wr_en) n_wr++;
      if (bus_err) check("bus_err_only_with_pcen", int'(PCEn), 1);
      if (PCEn) begin
        check("pcen_expected", int'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          mon_e = sbq.pop_front();
          check("latency", cyc - start + 1, mon_e.lat);
          check("bus_req_cycles", n_breq, mon_e.breq);
          check("rf_write_pulses", n_wr, mon_e.wr);
          check("rf_src_sel", int'(RFWriteDataSrcMuxSel), mon_e.rfsel);
          check("alu_control", int'(ALUControl), mon_e.alu);
          check("alu_src_sel", int'(AluSrcMuxSel), mon_e.alusrc);
          check("imm_type", int'(immExtType), mon_e.imm);
          check("bus_err", int'(bus_err), mon_e.berr);
          check("branch_sel", int'({Bbranch, Jbranch, JIbranch}), mon_e.br);
          check("load_type", int'(loadType), mon_e.ld);
          check("store_type", int'(storeType), mon_e.st);
          check("dmem_wr_en", int'(dataMem_wr_en), mon_e.dmem);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input int w);
    sbq.push_back(model(ins, w));
    cur_wait = w;
    @(posedge clk); #1;
    instrCode   = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instrCode   = $urandom;
    for (int k = 0; k < 3 * BT && sbq.size() != 0; k++) @(posedge clk);
    if (sbq.size() != 0) begin
      check("completion_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  initial begin
    int pulses, k;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) check("reset_outputs", int'(outs), 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(negedge clk) check("idle_outputs", int'(outs), 0);

    mon_en = 1'b1;
    issue(32'h002081B3, 0);     // add
    issue(32'h402081B3, 0);     // sub
    issue(32'h4020D193, 0);     // srai
    issue(32'h00108093, 0);     // addi
    issue(32'h0000A183, 3);     // lw, 3 wait cycles
    issue(32'h0020A023, 1000);  // sw, never ready
    issue(32'h0000A183, BT - 1);
    issue(32'h0020A023, BT - 1);
`ifndef ILLEGAL_TRAP_EN
    issue(32'h0000007F, 0);
`endif
    for (int n = 0; n < 200; n++) begin
`ifdef ILLEGAL_TRAP_EN
      issue(rand_instr($urandom_range(0, 8)), pick_wait());
`else
      issue(rand_instr($urandom_range(0, 9)), pick_wait());
`endif
    end
    mon_en = 1'b0;

    // Reset while a load is stalled on the bus
    cur_wait = 1000;
    @(posedge clk); #1;
    instrCode = 32'h0000A183; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    k = 0;
    while (!bus_req && k < 10) begin @(posedge clk); #1; k++; end
    check("reached_load_mem", int'(bus_req), 1);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk) check("reset_mid_mem_outputs", int'(outs), 0);
    pulses = 0;
    repeat (6) @(negedge clk) pulses += int'(regFile_wr_en) + int'(PCEn);
    check("no_pulse_after_reset", pulses, 0);

    @(posedge clk); #1;
    instrCode = 32'h0000007F; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    pulses = 0;
    k = 0;
    repeat (8) @(negedge clk) begin
      pulses += int'(PCEn);
      k      += int'(regFile_wr_en) + int'(illegal_instr);
    end
`ifdef ILLEGAL_TRAP_EN
    check("trap_no_pcen", pulses, 0);
    check("trap_illegal_held", int'(illegal_instr), 1);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk) check("trap_cleared_by_reset", int'(outs), 0);
`else
    check("unknown_op_one_pcen", pulses, 1);
    check("unknown_op_no_write_no_illegal", k, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
